noise_scroll_gen: RTL and testbench
===================================

// Module: noise_scroll_gen
// PURPOSE
//  Parametrised successor test-pattern/video timing generator. Produces HSYNC/VSYNC/DE and
//  8-bit RGB for any progressive timing. Patterns: black, static LFSR noise, vertically
//  scrolling LFSR noise at programmable speed, 8-bar colour bars. Drives the video DAC/HDMI TX path.
// PARAMETERS
//  H_SYNCLEN    62      hsync width, pixels       | V_SYNCLEN    6    vsync width, lines
//  H_BACKPORCH  60      h back porch, pixels      | V_BACKPORCH  30   v back porch, lines
//  H_ACTIVE     720     active pixels; multiple of 8 | V_ACTIVE  480  active lines
//  H_TOTAL      858     pixels/line               | V_TOTAL      525  lines/frame
//  CNT_W        10      h/v counter width; 2**CNT_W > H_TOTAL, V_TOTAL
//  LFSR_W       16      noise LFSR width
//  LFSR_TAPS    16'hD008  feedback mask (bits 15,14,12,3)
//  SEED         16'h0001  LFSR reload value; all-zero is substituted by 1
//  DENSITY      7       noise pixel lit when LFSR[LFSR_W-1 -: DENSITY] all ones
// PORTS
//  clk27        in   1   pixel clock
//  reset        in   1   synchronous, active-high reset
//  mode         in   2   0 black, 1 static noise, 2 scrolling noise, 3 colour bars
//  scroll_speed in   4   LFSR seed steps per frame in mode 2 (0 = frozen)
//  R_out/G_out/B_out out 8 each  pixel data, 0 outside active area
//  HSYNC_out    out  1   negative-polarity hsync  | VSYNC_out  out 1  negative-polarity vsync
//  ENABLE_out   out  1   data enable (active area)
//  frame_start  out  1   1-cycle pulse, aligned with outputs for counter position (0,0)
// BEHAVIOUR
//  - h_cnt 0..H_TOTAL-1 wraps; v_cnt increments when h_cnt==H_TOTAL-1, wraps after V_TOTAL-1.
//  - X_START=H_SYNCLEN+H_BACKPORCH, Y_START=V_SYNCLEN+V_BACKPORCH; active when
//    X_START<=h_cnt<X_START+H_ACTIVE and Y_START<=v_cnt<Y_START+V_ACTIVE.
//  - All outputs registered; 1-cycle latency from counters; sync, DE, RGB, frame_start mutually aligned.
//  - HSYNC_out=0 while h_cnt<H_SYNCLEN; VSYNC_out=0 while v_cnt<V_SYNCLEN (whole lines).
//  - mode/scroll_speed captured into mode_q/speed_q only at h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1;
//    mid-frame changes have no effect until next frame.
//  - LFSR step: next={s[LFSR_W-2:0], ^(s & LFSR_TAPS)}; zero state forced to 1 (lock-up guard).
//  - frame_seed: mode 1 holds SEED; mode 2 steps once per cycle on v_cnt==0 while h_cnt<speed_q
//    (exactly speed_q steps/frame); modes 0/3 hold value. Mode entry 1->2 starts from SEED.
//  - pix_lfsr loads frame_seed at h_cnt==0 && v_cnt==Y_START; steps once per active pixel
//    (modes 1,2 only); otherwise held.
//  - Noise pixel: R=G=B=FF if lit (per DENSITY) else 00, using pix_lfsr before its step.
//  - Bars: idx=(h_cnt-X_START)/(H_ACTIVE/8) via comparator chain; white,yellow,cyan,green,
//    magenta,red,blue,black; component levels FF/00.
//  - Outside active area R/G/B=0 in all modes.
//  - Reset: h_cnt=v_cnt=0, HSYNC_out=VSYNC_out=0, ENABLE_out=0, RGB=0, frame_start=0,
//    mode_q=0, speed_q=0, frame_seed=pix_lfsr=SEED. Reset mid-frame: timing restarts at (0,0)
//    first cycle after deassert; first frame is black until next capture point.
// CONFIGURATION
//  VGEN_GRID_EN defined: in modes 1-3, R_out |= 8'hD0 where active-relative x or y has low
//  6 bits zero (64-pixel grid); G/B unchanged. Undefined: no overlay logic, noise R=G=B.
// TESTING
//  1 Default params, mode 0: HSYNC low 62 of 858 cycles, VSYNC low 6 lines, 720x480 DE, frame=450450 cycles.
//  2 Mode 1, two frames: first-active-pixel stream identical frame to frame; first LFSR=16'h0001.
//  3 Mode 2, speed 3: pix_lfsr at (X_START,Y_START) of frame N+1 = SEED stepped 3*N times;
//    speed 0 -> frames identical.
//  4 Mode 3: active x=0 -> FF,FF,FF; x=90 -> FF,FF,00; x=719 -> 00,00,00.
//  5 Change mode 3->0 at v_cnt=200: bars continue to frame end, black from next frame_start.
//  6 Assert reset at v_cnt=300 for 2 cycles: all outputs reset values, frame_start 1 frame later, SEED=0 param -> LFSR=1.

Source files
------------

// File: rtl/noise_scroll_gen.sv
// Progressive video timing and test-pattern generator: black, static/scrolling LFSR noise, 8 colour bars.
// Optional build macro VGEN_GRID_EN adds a 64-pixel red grid overlay in the non-black modes.
module noise_scroll_gen #(
  parameter int               H_SYNCLEN   = 62,
  parameter int               H_BACKPORCH = 60,
  parameter int               H_ACTIVE    = 720,
  parameter int               H_TOTAL     = 858,
  parameter int               V_SYNCLEN   = 6,
  parameter int               V_BACKPORCH = 30,
  parameter int               V_ACTIVE    = 480,
  parameter int               V_TOTAL     = 525,
  parameter int               CNT_W       = 10,
  parameter int               LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hD008,
  parameter logic [LFSR_W-1:0] SEED       = 16'h0001,
  parameter int               DENSITY     = 7
) (
  input  logic       clk27,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [3:0] scroll_speed,
  output logic [7:0] R_out,
  output logic [7:0] G_out,
  output logic [7:0] B_out,
  output logic       HSYNC_out,
  output logic       VSYNC_out,
  output logic       ENABLE_out,
  output logic       frame_start
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNCLEN);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNCLEN);
  localparam logic [CNT_W-1:0] X_START_C = CNT_W'(H_SYNCLEN + H_BACKPORCH);
  localparam logic [CNT_W-1:0] Y_START_C = CNT_W'(V_SYNCLEN + V_BACKPORCH);
  localparam logic [CNT_W-1:0] X_END_C   = CNT_W'(H_SYNCLEN + H_BACKPORCH + H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_END_C   = CNT_W'(V_SYNCLEN + V_BACKPORCH + V_ACTIVE);
  localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_ONE : SEED;

  // An all-zero state would lock the shift register, so it is replaced by 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    return (n == '0) ? LFSR_ONE : n;
  endfunction

  logic [CNT_W-1:0]  h_cnt, v_cnt, x_rel;
  logic [1:0]        mode_q;
  logic [3:0]        speed_q;
  logic [LFSR_W-1:0] frame_seed, pix_lfsr;
  logic              frame_end, vld_p0, lit;
  logic [2:0]        bar_idx;
  logic [7:0]        r_p0, g_p0, b_p0;

  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign vld_p0    = (h_cnt >= X_START_C) && (h_cnt < X_END_C) &&
                     (v_cnt >= Y_START_C) && (v_cnt < Y_END_C);
  assign x_rel     = h_cnt - X_START_C;
  assign lit       = &pix_lfsr[LFSR_W-1 -: DENSITY];

`ifdef VGEN_GRID_EN
  logic [CNT_W-1:0] y_rel;
  assign y_rel = v_cnt - Y_START_C;
`endif

  // Stage p0: raster counters, per-frame control capture and noise state
  always_ff @(posedge clk27) begin
    if (reset) begin
      h_cnt      <= '0;
      v_cnt      <= '0;
      mode_q     <= 2'd0;
      speed_q    <= 4'd0;
      frame_seed <= SEED_EFF;
      pix_lfsr   <= SEED_EFF;
    end else begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end

      if (frame_end) begin
        mode_q  <= mode;
        speed_q <= scroll_speed;
      end

      // Scrolling takes exactly speed_q seed steps at the top of each frame.
      case (mode_q)
        2'd1:    frame_seed <= SEED_EFF;
        2'd2:    if ((v_cnt == '0) && (h_cnt < CNT_W'(speed_q))) frame_seed <= lfsr_step(frame_seed);
        default: ;
      endcase

      if ((h_cnt == '0) && (v_cnt == Y_START_C))
        pix_lfsr <= frame_seed;
      else if (vld_p0 && ((mode_q == 2'd1) || (mode_q == 2'd2)))
        pix_lfsr <= lfsr_step(pix_lfsr);
    end
  end

  always_comb begin
    r_p0    = 8'h00;
    g_p0    = 8'h00;
    b_p0    = 8'h00;
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++)
      if (x_rel >= CNT_W'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
    if (vld_p0) begin
      case (mode_q)
        2'd1, 2'd2: begin
          r_p0 = {8{lit}};
          g_p0 = {8{lit}};
          b_p0 = {8{lit}};
        end
        // Bar order white..black maps to inverted index bits: R=~idx[1], G=~idx[2], B=~idx[0].
        2'd3: begin
          r_p0 = {8{~bar_idx[1]}};
          g_p0 = {8{~bar_idx[2]}};
          b_p0 = {8{~bar_idx[0]}};
        end
        default: ;
      endcase
`ifdef VGEN_GRID_EN
      if ((mode_q != 2'd0) && ((x_rel[5:0] == 6'd0) || (y_rel[5:0] == 6'd0)))
        r_p0 = r_p0 | 8'hD0;
`endif
    end
  end

  // Stage p1: registered outputs, all aligned one cycle behind the counters
  always_ff @(posedge clk27) begin
    if (reset) begin
      HSYNC_out   <= 1'b0;
      VSYNC_out   <= 1'b0;
      ENABLE_out  <= 1'b0;
      R_out       <= 8'h00;
      G_out       <= 8'h00;
      B_out       <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      HSYNC_out   <= (h_cnt >= H_SYNC_C);
      VSYNC_out   <= (v_cnt >= V_SYNC_C);
      ENABLE_out  <= vld_p0;
      R_out       <= r_p0;
      G_out       <= g_p0;
      B_out       <= b_p0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_noise_scroll_gen.sv
// Directed bench for noise_scroll_gen on a reduced 48x12 raster (32x6 active, 4-pixel bars).
module tb_noise_scroll_gen;
  localparam int HT = 48;
  localparam int VT = 12;
  localparam int FRAME = HT * VT;

  logic       clk27 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [3:0] scroll_speed = 4'd0;
  logic [7:0] R_out, G_out, B_out, R_z, G_z, B_z;
  logic       HSYNC_out, VSYNC_out, ENABLE_out, frame_start;
  logic       HSYNC_z, VSYNC_z, ENABLE_z, frame_start_z;
  logic [27:0] vec, vec0;

  int checks = 0;
  int errors = 0;
  logic [27:0] obs[FRAME];
  logic [27:0] obs0[FRAME];
  logic [27:0] expv[FRAME];
  logic [23:0] bar_col[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  always #5 clk27 = ~clk27;

  noise_scroll_gen #(
    .H_SYNCLEN(4), .H_BACKPORCH(4), .H_ACTIVE(32), .H_TOTAL(HT),
    .V_SYNCLEN(2), .V_BACKPORCH(2), .V_ACTIVE(6), .V_TOTAL(VT),
    .CNT_W(6), .LFSR_W(16), .LFSR_TAPS(16'hD008), .SEED(16'h0001), .DENSITY(2)
  ) dut (
    .clk27(clk27), .reset(reset), .mode(mode), .scroll_speed(scroll_speed),
    .R_out(R_out), .G_out(G_out), .B_out(B_out), .HSYNC_out(HSYNC_out),
    .VSYNC_out(VSYNC_out), .ENABLE_out(ENABLE_out), .frame_start(frame_start)
  );

  noise_scroll_gen #(
    .H_SYNCLEN(4), .H_BACKPORCH(4), .H_ACTIVE(32), .H_TOTAL(HT),
    .V_SYNCLEN(2), .V_BACKPORCH(2), .V_ACTIVE(6), .V_TOTAL(VT),
    .CNT_W(6), .LFSR_W(16), .LFSR_TAPS(16'hD008), .SEED(16'h0000), .DENSITY(2)
  ) dut0 (
    .clk27(clk27), .reset(reset), .mode(mode), .scroll_speed(scroll_speed),
    .R_out(R_z), .G_out(G_z), .B_out(B_z), .HSYNC_out(HSYNC_z),
    .VSYNC_out(VSYNC_z), .ENABLE_out(ENABLE_z), .frame_start(frame_start_z)
  );

  assign vec  = {frame_start, HSYNC_out, VSYNC_out, ENABLE_out, R_out, G_out, B_out};
  assign vec0 = {frame_start_z, HSYNC_z, VSYNC_z, ENABLE_z, R_z, G_z, B_z};

  function automatic logic [15:0] tb_step(input logic [15:0] s);
    logic [15:0] n;
    n = {s[14:0], ^(s & 16'hD008)};
    return (n == 16'h0) ? 16'h0001 : n;
  endfunction

  // Expected output vector of every cycle of one frame, starting at the frame_start cycle.
  task automatic build_exp(input int m, input logic [15:0] seed);
    logic [15:0] pix;
    logic        de, lit;
    logic [23:0] rgb;
    int          h, v;
    pix = seed;
    for (int p = 0; p < FRAME; p++) begin
      h   = p % HT;
      v   = p / HT;
      de  = (h >= 8) && (h < 40) && (v >= 4) && (v < 10);
      rgb = 24'h0;
      if (de) begin
        if (m == 1 || m == 2) begin
          lit = &pix[15:14];
          pix = tb_step(pix);
          rgb = lit ? 24'hFFFFFF : 24'h000000;
        end else if (m == 3) begin
          rgb = bar_col[(h - 8) / 4];
        end
      end
      expv[p] = {(p == 0), (h >= 4), (v >= 2), de, rgb};
    end
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 2 * FRAME) begin
      @(negedge clk27);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_wait: frame_start=%b after %0d cycles, required 1", frame_start, n);
    end
  endtask

  // Records one frame from the current frame_start cycle; leaves the bench on the next one.
  task automatic capture(input int chg_at, input logic [1:0] chg_mode);
    for (int i = 0; i < FRAME; i++) begin
      if (i == chg_at) mode = chg_mode;
      obs[i]  = vec;
      obs0[i] = vec0;
      @(negedge clk27);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode  = 2'd0;
    repeat (3) @(negedge clk27);
    checks++;
    if (vec !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected %h", vec, 28'h0);
    end
    checks++;
    if (vec0 !== 28'h0) begin
      errors++;
      $display("FAIL reset_outputs_seed0: got %h, expected %h", vec0, 28'h0);
    end
    reset = 1'b0;
    @(negedge clk27);
    checks++;
    if (vec !== 28'h8000000) begin
      errors++;
      $display("FAIL first_after_reset: got %h, expected %h", vec, 28'h8000000);
    end
    capture(-1, 2'd0);
    build_exp(0, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL mode0_frame[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_period: frame_start=%b after %0d cycles, expected 1", frame_start, FRAME);
    end
  endtask

  task automatic test_static_noise();
    wait_fs();
    mode = 2'd1;
    capture(-1, 2'd0);
    build_exp(0, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL midframe_mode_ignored[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    build_exp(1, 16'h0001);
    for (int f = 0; f < 2; f++) begin
      capture(-1, 2'd0);
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL static_noise_f%0d[%0d]: got %h, expected %h", f, i, obs[i], expv[i]);
        end
        checks++;
        if (obs0[i] !== expv[i]) begin
          errors++;
          $display("FAIL seed0_noise_f%0d[%0d]: got %h, expected %h", f, i, obs0[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_scroll();
    logic [15:0] seeds[5] = '{16'h0001, 16'h0008, 16'h0044, 16'h0044, 16'h0044};
    wait_fs();
    mode = 2'd2;
    scroll_speed = 4'd3;
    for (int f = 0; f < 5; f++) begin
      if (f == 2) scroll_speed = 4'd0;
      capture(-1, 2'd0);
      build_exp((f == 0) ? 1 : 2, seeds[f]);
      for (int i = 0; i < FRAME; i++) begin
        checks++;
        if (obs[i] !== expv[i]) begin
          errors++;
          $display("FAIL scroll_f%0d[%0d]: got %h, expected %h", f, i, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_bars();
    wait_fs();
    mode = 2'd3;
    capture(-1, 2'd0);
    build_exp(2, 16'h0044);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL bars_lead_frame[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    capture(-1, 2'd0);
    checks++;
    if (obs[4*HT+8][23:0] !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL bar_x0: got %h, expected FFFFFF", obs[4*HT+8][23:0]);
    end
    checks++;
    if (obs[4*HT+12][23:0] !== 24'hFFFF00) begin
      errors++;
      $display("FAIL bar_x4: got %h, expected FFFF00", obs[4*HT+12][23:0]);
    end
    checks++;
    if (obs[9*HT+39][23:0] !== 24'h000000) begin
      errors++;
      $display("FAIL bar_x31: got %h, expected 000000", obs[9*HT+39][23:0]);
    end
    build_exp(3, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL bars_frame[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_mode_change();
    wait_fs();
    capture(7 * HT + 20, 2'd0);
    build_exp(3, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL bars_until_frame_end[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    capture(100, 2'd3);
    build_exp(0, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL black_next_frame[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_fs();
    repeat (7 * HT + 20) @(negedge clk27);
    checks++;
    if (vec !== {4'b0111, 24'h00FF00}) begin
      errors++;
      $display("FAIL pre_reset_pixel: got %h, expected %h", vec, {4'b0111, 24'h00FF00});
    end
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk27);
      checks++;
      if (vec !== 28'h0) begin
        errors++;
        $display("FAIL mid_reset_c%0d: got %h, expected %h", c, vec, 28'h0);
      end
      checks++;
      if (vec0 !== 28'h0) begin
        errors++;
        $display("FAIL mid_reset_seed0_c%0d: got %h, expected %h", c, vec0, 28'h0);
      end
    end
    reset = 1'b0;
    @(negedge clk27);
    checks++;
    if (vec !== 28'h8000000) begin
      errors++;
      $display("FAIL restart_at_origin: got %h, expected %h", vec, 28'h8000000);
    end
    capture(-1, 2'd0);
    build_exp(0, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL post_reset_black[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    mode = 2'd0;
    capture(-1, 2'd0);
    build_exp(3, 16'h0001);
    for (int i = 0; i < FRAME; i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        errors++;
        $display("FAIL post_reset_bars[%0d]: got %h, expected %h", i, obs[i], expv[i]);
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_period: frame_start=%b, expected 1", frame_start);
    end
  endtask

  initial begin
    test_reset();
    test_static_noise();
    test_scroll();
    test_bars();
    test_mode_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
